mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq_pkg.sv | 15 +
 rtl/mul_seq.sv | 116 +++++++++++
 tb/tb_mul_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package mul_seq_pkg;

    localparam int unsigned QW_DEFAULT = 17;
    localparam int unsigned DW_DEFAULT = 13;
    localparam int unsigned RW_DEFAULT = 16;
    localparam int unsigned PW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: dividend = quotient * divisor + remainder.
// One multiplier bit is consumed per RUN cycle; the result is held in DONE
// until the consumer accepts it.
// Optional macro MUL_SEQ_EARLY_EXIT_EN: leave RUN as soon as the remaining
// multiplier bits are all zero instead of always running DW cycles.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int unsigned QW = QW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned RW = RW_DEFAULT,
    parameter int unsigned PW = PW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] quotient,
    input  logic [DW-1:0] divisor,
    input  logic [RW-1:0] remainder,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] dividend,
    output logic          busy
);

    localparam int unsigned CW     = $clog2(DW + 1);
    localparam int unsigned PW_MIN = ((QW + DW > RW) ? (QW + DW) : RW) + 1;

    // Result width must hold the full product plus addend without overflow.
    if (PW < PW_MIN) begin : g_pw_check
        $error("mul_seq: PW too small for QW/DW/RW");
    end

    state_e        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic [PW-1:0] acc_q,    acc_d;
    logic [PW-1:0] mcand_q,  mcand_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          last_d;

    // One shift-add step plus the decision whether this step is the last one.
    always_comb begin
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        last_d   = (mplier_d == '0);
`else
        last_d   = (cnt_q == CW'(DW - 1));
`endif
    end

    // Control FSM and datapath registers; reset wins over every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        acc_q      <= PW'(remainder);
                        mcand_q    <= PW'(quotient);
                        mplier_q   <= divisor;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    if (last_d) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    // Result is masked to zero whenever it is not being offered.
    assign dividend  = out_valid_q ? acc_q : '0;

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq (default parameters).
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] quotient;
    logic [12:0] divisor;
    logic [15:0] remainder;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dividend;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int lat;

    mul_seq #(.QW(17), .DW(13), .RW(16), .PW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dividend  (dividend),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected cycles from accept edge to first out_valid.
    function automatic int exp_lat(input logic [12:0] d);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        int l = 1;
        for (int i = 0; i < 13; i++)
            if (d[i]) l = i + 1;
        return l;
`else
        return 13;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands in IDLE and let one edge accept them.
    task automatic start_op(input logic [16:0] q, input logic [12:0] d, input logic [15:0] r);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("ready_before_start", 64'(in_ready), 64'd1);
        quotient  = q;
        divisor   = d;
        remainder = r;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    // Count cycles until out_valid, bounded.
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
        chk({tag, "_div_zero"}, 64'(dividend), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [16:0] q, input logic [12:0] d,
                          input logic [15:0] r, input logic [31:0] exp);
        int c;
        start_op(q, d, r);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_result(c);
        chk({tag, "_lat"}, 64'(c), 64'(exp_lat(d)));
        chk({tag, "_res"}, 64'(dividend), 64'(exp));
        finish_op(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        quotient  = '0;
        divisor   = '0;
        remainder = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dividend", 64'(dividend), 64'd0);

        run_op("basic", 17'h10000, 13'h1C7, 16'h0010, 32'h01C70010);
        run_op("max",   17'h1FFFF, 13'h1FFF, 16'hFFFF, 32'h3FFEE000);
        run_op("zero_d", 17'h1234, 13'h0, 16'hABCD, 32'h0000ABCD);
        run_op("one_d",  17'h7,    13'h1, 16'h0,    32'h7);
        run_op("zero_q", 17'h0,    13'h1FFF, 16'h5, 32'h5);
        run_op("msb_d",  17'h1,    13'h1000, 16'h0, 32'h1000);

        // Backpressure: result held while out_ready stays low.
        start_op(17'h3, 13'h5, 16'h1);
        wait_result(lat);
        chk("bp_lat", 64'(lat), 64'(exp_lat(13'h5)));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_vld", 64'(out_valid), 64'd1);
            chk("bp_div", 64'(dividend), 64'd16);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        finish_op("bp");

        // in_valid held with changing operands while busy.
        start_op(17'h10000, 13'h1C7, 16'h0010);
        in_valid = 1'b1;
        lat = 0;
        while (!out_valid && lat < 100) begin
            quotient  = 17'h1FFFF - 17'(lat);
            divisor   = 13'h1FFF;
            remainder = 16'hFFFF;
            chk("bsy_in_ready", 64'(in_ready), 64'd0);
            tick();
            lat++;
        end
        chk("bsy_lat", 64'(lat), 64'(exp_lat(13'h1C7)));
        chk("bsy_res", 64'(dividend), 64'h01C70010);
        quotient  = 17'h3;
        divisor   = 13'h5;
        remainder = 16'h1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bsy_idle_rdy", 64'(in_ready), 64'd1);
        chk("bsy_idle_busy", 64'(busy), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("bsy_2nd_acc", 64'(busy), 64'd1);
        wait_result(lat);
        chk("bsy_2nd_lat", 64'(lat), 64'(exp_lat(13'h5)));
        chk("bsy_2nd_res", 64'(dividend), 64'd16);
        finish_op("bsy2");

        // Reset during the fifth RUN cycle.
        start_op(17'h10000, 13'h1C7, 16'h0010);
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy_pre", 64'(busy), 64'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        chk("mid_vld", 64'(out_valid), 64'd0);
        chk("mid_in_ready", 64'(in_ready), 64'd1);
        chk("mid_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("mid_vld_hold", 64'(out_valid), 64'd0);
        end
        run_op("post_rst", 17'h3, 13'h5, 16'h1, 32'd16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
